// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu_pkg: shared widths and the fetch entry type of the CPU front end  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package cpu_pkg;

  localparam int ADDR_W              = 8;
  localparam int DATA_W              = 8;
  localparam int FETCH_DEPTH_DEFAULT = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_fifo: synchronous FIFO with push, pop, clear and occupancy     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int WIDTH = $bits(fetch_entry_t),
  parameter int DEPTH = FETCH_DEPTH_DEFAULT,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clear,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty,
  output logic [LVL_W-1:0] o_level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_pop;
  logic             do_push;

  assign o_full  = (level_q == LVL_W'(DEPTH));
  assign o_empty = (level_q == '0);
  assign o_level = level_q;
  assign o_head  = mem_q[rd_ptr_q];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_pop  = i_pop & ~o_empty;
  assign do_push = i_push & (~o_full | do_pop);

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    level_d  = level_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = i_push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
    if (i_clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      level_d  = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset; entries are only observed below the level.
  always_ff @(posedge i_clk) begin
    mem_q <= mem_d;
  end

endmodule
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_buffer: issues program memory reads, tags returning data with  |
// | its address and queues it for the decoder; flush drops stale reads.  |
// | Optional same-cycle bypass when empty: define FETCH_BUFFER_BYPASS_EN |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fetch_buffer #(
  parameter int DATA_W      = cpu_pkg::DATA_W,
  parameter int ADDR_W      = cpu_pkg::ADDR_W,
  parameter int MEM_LATENCY = 1,
  parameter int DEPTH       = cpu_pkg::FETCH_DEPTH_DEFAULT
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_rd,
  input  logic [ADDR_W-1:0]            i_address,
  input  logic                         i_flush,
  output logic                         o_mem_rd,
  output logic [ADDR_W-1:0]            o_mem_addr,
  input  logic [DATA_W-1:0]            i_mem_data,
  output logic                         o_instr_valid,
  output logic [DATA_W-1:0]            o_instr,
  output logic [ADDR_W-1:0]            o_instr_addr,
  input  logic                         i_instr_ready,
  output logic [$clog2(DEPTH+1)-1:0]   o_level,
  output logic                         o_overflow
);

  localparam int ENTRY_W = ADDR_W + DATA_W;

  logic                   mem_rd;
  logic [MEM_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
  logic [ADDR_W-1:0]      pipe_addr_q [MEM_LATENCY];
  logic [ADDR_W-1:0]      pipe_addr_d [MEM_LATENCY];
  logic                   overflow_q, overflow_d;
  logic                   cap_vld;
  logic [ENTRY_W-1:0]     cap_entry;
  logic [ENTRY_W-1:0]     head_entry;
  logic                   bypass_vld;
  logic                   fifo_push;
  logic                   fifo_pop;
  logic                   fifo_full;
  logic                   fifo_empty;

  // A strobe coinciding with a jump belongs to the old PC and is never issued.
  assign mem_rd     = i_rd & ~i_flush & ~i_reset;
  assign o_mem_rd   = mem_rd;
  assign o_mem_addr = i_reset ? '0 : i_address;

  always_comb begin
    pipe_vld_d     = '0;
    pipe_addr_d    = pipe_addr_q;
    pipe_vld_d[0]  = mem_rd;
    pipe_addr_d[0] = i_address;
    for (int i = 1; i < MEM_LATENCY; i++) begin
      pipe_vld_d[i]  = pipe_vld_q[i-1] & ~i_flush;
      pipe_addr_d[i] = pipe_addr_q[i-1];
    end
  end

  assign cap_vld   = pipe_vld_q[MEM_LATENCY-1] & ~i_flush;
  assign cap_entry = {pipe_addr_q[MEM_LATENCY-1], i_mem_data};

`ifdef FETCH_BUFFER_BYPASS_EN
  assign bypass_vld = cap_vld & fifo_empty;
`else
  assign bypass_vld = 1'b0;
`endif

  // A bypassed word taken by the decoder this cycle never enters the FIFO.
  assign fifo_pop  = ~fifo_empty & i_instr_ready;
  assign fifo_push = cap_vld & ~(bypass_vld & i_instr_ready);

  assign o_instr_valid                = ~fifo_empty | bypass_vld;
  assign {o_instr_addr, o_instr}      = bypass_vld ? cap_entry : head_entry;
  assign o_overflow                   = overflow_q;
  assign overflow_d = overflow_q | (fifo_push & fifo_full & ~fifo_pop);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pipe_vld_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      pipe_vld_q <= pipe_vld_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge i_clk) begin
    pipe_addr_q <= pipe_addr_d;
  end

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_clear     (i_flush),
    .i_push      (fifo_push),
    .i_push_data (cap_entry),
    .i_pop       (fifo_pop),
    .o_head      (head_entry),
    .o_full      (fifo_full),
    .o_empty     (fifo_empty),
    .o_level     (o_level)
  );

endmodule
`default_nettype wire

// File: tb/tb_fetch_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fetch_buffer: directed and random checks of fetch_buffer against  |
// | a queue-based reference model. Revision: 1.0                        |
// +----------------------------------------------------------------------+
module tb_fetch_buffer;

  localparam int DATA_W      = 8;
  localparam int ADDR_W      = 8;
  localparam int MEM_LATENCY = 1;
  localparam int DEPTH       = 4;
  localparam int LVL_W       = $clog2(DEPTH + 1);
`ifdef FETCH_BUFFER_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              rd;
  logic [ADDR_W-1:0] address;
  logic              flush;
  logic              ready;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              instr_valid;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_addr;
  logic [LVL_W-1:0]  level;
  logic              overflow;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fetch_buffer #(
    .DATA_W      (DATA_W),
    .ADDR_W      (ADDR_W),
    .MEM_LATENCY (MEM_LATENCY),
    .DEPTH       (DEPTH)
  ) dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_rd          (rd),
    .i_address     (address),
    .i_flush       (flush),
    .o_mem_rd      (mem_rd),
    .o_mem_addr    (mem_addr),
    .i_mem_data    (mem_data),
    .o_instr_valid (instr_valid),
    .o_instr       (instr),
    .o_instr_addr  (instr_addr),
    .i_instr_ready (ready),
    .o_level       (level),
    .o_overflow    (overflow)
  );

  // Program memory: contents are a fixed function of the address.
  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return (a * 8'd13) ^ 8'h5A;
  endfunction

  logic [DATA_W-1:0] mem_pipe [MEM_LATENCY];
  always @(posedge clk) begin
    mem_pipe[0] <= mem_word(mem_addr);
    for (int i = 1; i < MEM_LATENCY; i++) mem_pipe[i] <= mem_pipe[i-1];
  end
  assign mem_data = mem_pipe[MEM_LATENCY-1];

  // Reference model: decoder-visible queue plus the list of issued reads.
  logic [15:0]       exp_q[$];
  logic [ADDR_W-1:0] infl_addr[$];
  int                infl_cyc[$];
  bit                exp_ovf = 1'b0;
  int                cyc = 0;

  function automatic bit cap_now();
    return !flush && infl_cyc.size() > 0 && infl_cyc[0] + MEM_LATENCY == cyc;
  endfunction

  function automatic bit exp_valid();
    return exp_q.size() > 0 || (BYP && cap_now());
  endfunction

  function automatic logic [15:0] exp_head();
    if (exp_q.size() > 0) return exp_q[0];
    return {infl_addr[0], mem_word(infl_addr[0])};
  endfunction

  task automatic drive(input bit r, input logic [ADDR_W-1:0] a, input bit f, input bit rdy);
    rd = r; address = a; flush = f; ready = rdy;
    #1;
  endtask

  task automatic step();
    bit          cap;
    bit          cons;
    logic [15:0] ent;
    @(posedge clk);
    cap = cap_now();
    ent = 16'h0;
    if (infl_cyc.size() > 0 && infl_cyc[0] + MEM_LATENCY == cyc) begin
      ent = {infl_addr[0], mem_word(infl_addr[0])};
      void'(infl_addr.pop_front());
      void'(infl_cyc.pop_front());
    end
    if (reset) begin
      exp_q.delete(); infl_addr.delete(); infl_cyc.delete(); exp_ovf = 1'b0;
    end else if (flush) begin
      exp_q.delete(); infl_addr.delete(); infl_cyc.delete();
    end else begin
      cons = BYP && cap && exp_q.size() == 0 && ready;
      if (exp_q.size() > 0 && ready) void'(exp_q.pop_front());
      if (cap && !cons) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(ent);
        else exp_ovf = 1'b1;
      end
      if (rd) begin
        infl_addr.push_back(address);
        infl_cyc.push_back(cyc);
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, 8'hA7, 1'b0, 1'b0);
    checks++;
    if (mem_rd !== 1'b0) begin errors++; $display("FAIL reset_mem_rd: got %b expected 0", mem_rd); end
    checks++;
    if (mem_addr !== 8'h00) begin errors++; $display("FAIL reset_mem_addr: got %h expected 00", mem_addr); end
    step();
    step();
    reset = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
    checks++;
    if (level !== '0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
  endtask

  task automatic test_latency();
    int seen_j;
    int exp_lat;
    exp_lat = BYP ? MEM_LATENCY : MEM_LATENCY + 1;
    for (int k = 0; k < 3; k++) begin
      seen_j = -1;
      for (int j = 0; j < 4; j++) begin
        drive(j == 0, 8'(k), 1'b0, 1'b1);
        if (instr_valid === 1'b1 && seen_j < 0) begin
          seen_j = j;
          checks++;
          if (instr_addr !== 8'(k)) begin errors++; $display("FAIL latency_addr: got %h expected %h", instr_addr, 8'(k)); end
          checks++;
          if (instr !== mem_word(8'(k))) begin errors++; $display("FAIL latency_data: got %h expected %h", instr, mem_word(8'(k))); end
        end
        checks++;
        if (level !== LVL_W'(exp_q.size())) begin errors++; $display("FAIL latency_level: got %0d expected %0d", level, exp_q.size()); end
        step();
      end
      checks++;
      if (seen_j != exp_lat) begin errors++; $display("FAIL latency_cycles: got %0d expected %0d", seen_j, exp_lat); end
    end
  endtask

  task automatic test_overflow();
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 8'(k), 1'b0, 1'b0);
      checks++;
      if (mem_rd !== 1'b1) begin errors++; $display("FAIL ovf_mem_rd: got %b expected 1", mem_rd); end
      step();
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    step();
    checks++;
    if (level !== LVL_W'(4)) begin errors++; $display("FAIL ovf_level: got %0d expected 4", level); end
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 8'h00, 1'b0, 1'b1);
      checks++;
      if (instr_valid !== 1'b1 || instr_addr !== 8'(k) || instr !== mem_word(8'(k))) begin
        errors++;
        $display("FAIL ovf_drain: got v=%b a=%h d=%h expected v=1 a=%h d=%h", instr_valid, instr_addr, instr, 8'(k), mem_word(8'(k)));
      end
      step();
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (instr_valid !== 1'b0 || overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_after_drain: got v=%b ovf=%b expected v=0 ovf=1", instr_valid, overflow);
    end
  endtask

  task automatic test_flush();
    bit seen;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 8'(8'h20 + k), 1'b0, 1'b0);
      step();
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (level !== LVL_W'(2)) begin errors++; $display("FAIL flush_pre_level: got %0d expected 2", level); end
    step();
    drive(1'b1, 8'h40, 1'b0, 1'b1);
    checks++;
    if (level !== '0 || instr_valid !== 1'b0) begin
      errors++; $display("FAIL flush_cleared: got level=%0d v=%b expected level=0 v=0", level, instr_valid);
    end
    step();
    seen = 1'b0;
    for (int j = 0; j < 4 && !seen; j++) begin
      drive(1'b0, 8'h00, 1'b0, 1'b1);
      if (instr_valid === 1'b1) begin
        seen = 1'b1;
        checks++;
        if (instr_addr !== 8'h40) begin errors++; $display("FAIL flush_next_addr: got %h expected 40", instr_addr); end
      end
      step();
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL flush_timeout: got no valid expected addr 40"); end
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL flush_ovf_kept: got %b expected 1", overflow); end
  endtask

  task automatic test_strobe_flush();
    drive(1'b1, 8'h55, 1'b1, 1'b1);
    checks++;
    if (mem_rd !== 1'b0) begin errors++; $display("FAIL sflush_mem_rd: got %b expected 0", mem_rd); end
    step();
    for (int j = 0; j < 5; j++) begin
      drive(1'b0, 8'h00, 1'b0, 1'b1);
      checks++;
      if (instr_valid !== 1'b0) begin errors++; $display("FAIL sflush_valid: got %b a=%h expected 0", instr_valid, instr_addr); end
      step();
    end
  endtask

  task automatic test_full_pushpop();
    reset = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    step();
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 8'(8'h10 + k), 1'b0, 1'b0);
      step();
    end
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    checks++;
    if (level !== LVL_W'(4)) begin errors++; $display("FAIL pp_pre_level: got %0d expected 4", level); end
    step();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (level !== LVL_W'(4)) begin errors++; $display("FAIL pp_level: got %0d expected 4", level); end
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL pp_overflow: got %b expected 0", overflow); end
    for (int k = 1; k < 5; k++) begin
      drive(1'b0, 8'h00, 1'b0, 1'b1);
      checks++;
      if (instr_valid !== 1'b1 || instr_addr !== 8'(8'h10 + k)) begin
        errors++; $display("FAIL pp_order: got v=%b a=%h expected v=1 a=%h", instr_valid, instr_addr, 8'(8'h10 + k));
      end
      step();
    end
  endtask

  task automatic test_random();
    bit          ev;
    logic [15:0] eh;
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 99) == 0);
      drive($urandom_range(0, 1) == 1, 8'($urandom_range(0, 255)),
            $urandom_range(0, 11) == 0, $urandom_range(0, 9) < 6);
      ev = exp_valid();
      checks++;
      if (instr_valid !== ev) begin errors++; $display("FAIL rnd_valid @%0d: got %b expected %b", cyc, instr_valid, ev); end
      if (ev) begin
        eh = exp_head();
        checks++;
        if ({instr_addr, instr} !== eh) begin errors++; $display("FAIL rnd_head @%0d: got %h expected %h", cyc, {instr_addr, instr}, eh); end
      end
      checks++;
      if (level !== LVL_W'(exp_q.size())) begin errors++; $display("FAIL rnd_level @%0d: got %0d expected %0d", cyc, level, exp_q.size()); end
      checks++;
      if (overflow !== exp_ovf) begin errors++; $display("FAIL rnd_overflow @%0d: got %b expected %b", cyc, overflow, exp_ovf); end
      checks++;
      if (mem_rd !== (rd && !flush && !reset)) begin
        errors++; $display("FAIL rnd_mem_rd @%0d: got %b expected %b", cyc, mem_rd, rd && !flush && !reset);
      end
      step();
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; rd = 1'b0; address = '0; flush = 1'b0; ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_latency();
    test_overflow();
    test_flush();
    test_strobe_flush();
    test_full_pushpop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
